float_compare_pipe: RTL and testbench

Parametrised, pipelined successor to the single-cycle float comparator. It accepts a stream of operand pairs in the team's custom sign-magnitude float format (1 sign, EXPONENT, MANTISSA bits) over a valid/ready handshake. Per beat it produces all three compare flags plus a selected result value: min, max, or a streamed min/max reduction. It sits between the shader ALU issue stage and the depth/clip units.

---
 rtl/float_compare_pipe_if.sv | 31 +++
 rtl/float_compare_pipe.sv | 159 +++++++++++++++
 tb/tb_float_compare_pipe.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/float_compare_pipe_if.sv
// Operand/result stream between the shader issue stage and the float comparator.
interface float_compare_pipe_if #(
    parameter int unsigned EXPONENT = 6,
    parameter int unsigned MANTISSA = 11
);
    localparam int unsigned W = EXPONENT + MANTISSA + 1;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic [W-1:0] in_y;
    logic [2:0]   in_op;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_value;
    logic         out_flag;
    logic         out_gt;
    logic         out_eq;
    logic         out_lt;

    modport master (
        output in_valid, in_x, in_y, in_op, in_last, out_ready,
        input  in_ready, out_valid, out_value, out_flag, out_gt, out_eq, out_lt
    );

    modport slave (
        input  in_valid, in_x, in_y, in_op, in_last, out_ready,
        output in_ready, out_valid, out_value, out_flag, out_gt, out_eq, out_lt
    );
endinterface

// File: rtl/float_compare_pipe.sv
// Two-stage sign-magnitude float comparator: compare flags, min/max select and a
// streamed min/max reduction with a single accumulator.
module float_compare_pipe #(
    parameter int unsigned EXPONENT = 6,
    parameter int unsigned MANTISSA = 11
) (
    input logic                 clk,
    input logic                 reset_n,
    float_compare_pipe_if.slave bus
);
    localparam int unsigned W = EXPONENT + MANTISSA + 1;
    localparam int unsigned M = W - 1;   // magnitude width; bit M is the sign

    typedef enum logic [2:0] {
        OP_GT   = 3'd0,
        OP_GE   = 3'd1,
        OP_EQ   = 3'd2,
        OP_LT   = 3'd3,
        OP_MIN  = 3'd4,
        OP_MAX  = 3'd5,
        OP_RMIN = 3'd6,
        OP_RMAX = 3'd7
    } op_e;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } rel_t;

    // Fold signs into an unsigned magnitude compare of a against b.
    function automatic rel_t resolve(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic magGt, input logic magEq);
        rel_t r;
        r = '0;
        if (magEq && (a[M-1:0] == '0)) begin
            r.eq = 1'b1;
        end else if (a[M] != b[M]) begin
            r.gt = ~a[M];
            r.lt = a[M];
        end else if (magEq) begin
            r.eq = 1'b1;
        end else if (magGt ^ a[M]) begin
            r.gt = 1'b1;
        end else begin
            r.lt = 1'b1;
        end
        return r;
    endfunction

    logic         readyEn;
    logic         advance;
    logic         acceptBeat;

    logic         s1Valid;
    logic [W-1:0] s1X;
    logic [W-1:0] s1Y;
    op_e          s1Op;
    logic         s1Last;
    logic         s1MagGt;
    logic         s1MagEq;

    logic [W-1:0] acc;
    logic         accFull;

    logic         outValid;
    logic [W-1:0] outValue;
    logic         outFlag;
    rel_t         outRel;

    logic         isReduce;
    logic         emitNext;
    logic         redTake;
    rel_t         pairRel;
    rel_t         accRel;
    rel_t         relNext;
    logic [W-1:0] redValue;
    logic [W-1:0] valueNext;
    logic         flagNext;

    assign advance    = ~outValid | bus.out_ready;
    assign acceptBeat = bus.in_valid & readyEn & advance;

    assign bus.in_ready  = readyEn & advance;
    assign bus.out_valid = outValid;
    assign bus.out_value = outValue;
    assign bus.out_flag  = outFlag;
    assign bus.out_gt    = outRel.gt;
    assign bus.out_eq    = outRel.eq;
    assign bus.out_lt    = outRel.lt;

    // S2 resolve: pair compare, accumulator compare and result select.
    always_comb begin
        isReduce  = (s1Op == OP_RMIN) || (s1Op == OP_RMAX);
        emitNext  = s1Valid & (~isReduce | s1Last);
        pairRel   = resolve(s1X, s1Y, s1MagGt, s1MagEq);
        accRel    = resolve(s1X, acc, s1X[M-1:0] > acc[M-1:0], s1X[M-1:0] == acc[M-1:0]);
        redTake   = ~accFull | ((s1Op == OP_RMIN) ? accRel.lt : accRel.gt);
        redValue  = redTake ? s1X : acc;
        valueNext = s1X;
        flagNext  = 1'b0;
        relNext   = pairRel;
        case (s1Op)
            OP_GT:   flagNext  = pairRel.gt;
            OP_GE:   flagNext  = pairRel.gt | pairRel.eq;
            OP_EQ:   flagNext  = pairRel.eq;
            OP_LT:   flagNext  = pairRel.lt;
            OP_MIN:  valueNext = pairRel.gt ? s1Y : s1X;
            OP_MAX:  valueNext = pairRel.lt ? s1Y : s1X;
            default: begin
                valueNext = redValue;
                relNext   = accFull ? accRel : rel_t'(3'b010);
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readyEn  <= 1'b0;
            s1Valid  <= 1'b0;
            s1X      <= '0;
            s1Y      <= '0;
            s1Op     <= OP_GT;
            s1Last   <= 1'b0;
            s1MagGt  <= 1'b0;
            s1MagEq  <= 1'b0;
            acc      <= '0;
            accFull  <= 1'b0;
            outValid <= 1'b0;
            outValue <= '0;
            outFlag  <= 1'b0;
            outRel   <= '0;
        end else begin
            readyEn <= 1'b1;
            if (advance) begin
                s1Valid <= acceptBeat;
                if (acceptBeat) begin
                    s1X     <= bus.in_x;
                    s1Y     <= bus.in_y;
                    s1Op    <= op_e'(bus.in_op);
                    s1Last  <= bus.in_last;
                    s1MagGt <= bus.in_x[M-1:0] > bus.in_y[M-1:0];
                    s1MagEq <= bus.in_x[M-1:0] == bus.in_y[M-1:0];
                end
                outValid <= emitNext;
                if (emitNext) begin
                    outValue <= valueNext;
                    outFlag  <= flagNext;
                    outRel   <= relNext;
                end
                // A last beat closes the reduction in the same cycle it reports.
                if (s1Valid && isReduce) begin
                    acc     <= redValue;
                    accFull <= ~s1Last;
                end
            end
        end
    end
endmodule

// File: tb/tb_float_compare_pipe.sv
// Scoreboarded bench for float_compare_pipe: directed table, reset, backpressure and random streams.
module tb_float_compare_pipe;
    localparam int unsigned EXPONENT = 6;
    localparam int unsigned MANTISSA = 11;
    localparam int unsigned W = EXPONENT + MANTISSA + 1;
    localparam int unsigned M = W - 1;
    localparam int NVEC = 21;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [2:0]   op;
        logic         last;
        logic         hasOut;
        logic         checkVal;
        logic [W-1:0] value;
        logic         flag;
        logic         gt;
        logic         eq;
        logic         lt;
    } vec_t;

    typedef struct {
        logic [W-1:0] value;
        logic         checkVal;
        logic         flag;
        logic         gt;
        logic         eq;
        logic         lt;
        int           tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    float_compare_pipe_if #(.EXPONENT(EXPONENT), .MANTISSA(MANTISSA)) bus ();

    float_compare_pipe #(.EXPONENT(EXPONENT), .MANTISSA(MANTISSA)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           readyMode = 0;
    int           phase = 0;
    logic [W-1:0] mAcc = '0;
    bit           mAccFull = 1'b0;
    vec_t         tbl[NVEC];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int keyOf(input logic [W-1:0] v);
        int k;
        k = int'(v[M-1:0]);
        return v[M] ? -k : k;
    endfunction

    function automatic int cmpRef(input logic [W-1:0] a, input logic [W-1:0] b);
        int ka;
        int kb;
        ka = keyOf(a);
        kb = keyOf(b);
        return (ka > kb) ? 1 : ((ka < kb) ? -1 : 0);
    endfunction

    // Reference model on signed integer keys; owns the model accumulator.
    task automatic modelBeat(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] op,
                             input logic last, output bit has, output exp_t e);
        int c;
        logic [W-1:0] nv;
        e.checkVal = 1'b1;
        e.flag = 1'b0;
        e.value = x;
        e.tag = 0;
        has = 1'b1;
        c = 0;
        if (op >= 3'd6) begin
            if (!mAccFull) begin
                nv = x;
            end else begin
                c = cmpRef(x, mAcc);
                if (op == 3'd6) nv = (c < 0) ? x : mAcc;
                else            nv = (c > 0) ? x : mAcc;
            end
            mAcc = nv;
            mAccFull = !last;
            e.value = nv;
            has = last;
        end else begin
            c = cmpRef(x, y);
            case (op)
                3'd0: e.flag = (c > 0);
                3'd1: e.flag = (c >= 0);
                3'd2: e.flag = (c == 0);
                3'd3: e.flag = (c < 0);
                3'd4: e.value = (c > 0) ? y : x;
                3'd5: e.value = (c < 0) ? y : x;
                default: ;
            endcase
            e.checkVal = (op >= 3'd4);
        end
        e.gt = (c > 0);
        e.eq = (c == 0);
        e.lt = (c < 0);
    endtask

    function automatic vec_t mkv(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic last, input logic hasOut, input logic checkVal,
                                 input logic [W-1:0] value, input logic flag,
                                 input logic gt, input logic eq, input logic lt);
        vec_t v;
        v.op = op; v.x = x; v.y = y; v.last = last; v.hasOut = hasOut; v.checkVal = checkVal;
        v.value = value; v.flag = flag; v.gt = gt; v.eq = eq; v.lt = lt;
        return v;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] op,
                        input logic last, input bit useTable, input vec_t tv, input int tag);
        bit ok;
        bit rdy;
        bit has;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_x = x;
        bus.in_y = y;
        bus.in_op = op;
        bus.in_last = last;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            ok = rdy;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept tag %0d: in_ready stayed 0, required 1 within 200 cycles", tag);
            return;
        end
        modelBeat(x, y, op, last, has, e);
        if (useTable) begin
            has = tv.hasOut;
            e.value = tv.value; e.checkVal = tv.checkVal; e.flag = tv.flag;
            e.gt = tv.gt; e.eq = tv.eq; e.lt = tv.lt;
        end
        e.tag = tag;
        if (has) sb.push_back(e);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, W'(sb.size()), W'(0));
    endtask

    function automatic logic [W-1:0] pickVal();
        logic [W-1:0] pool [8];
        pool[0] = 18'h00000; pool[1] = 18'h20000; pool[2] = 18'h0F800; pool[3] = 18'h2F800;
        pool[4] = 18'h10000; pool[5] = 18'h30000; pool[6] = 18'h1FFFF; pool[7] = 18'h3FFFF;
        if ($urandom_range(0, 2) == 0) return W'($urandom);
        return pool[$urandom_range(0, 7)];
    endfunction

    // out_ready driver: 0 always, 1 pattern 1,0,0, 2 random, else held low.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            phase++;
            case (readyMode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = ((phase % 3) == 0);
                2: bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: scoreboard pop, one-hot, stall hold and in_ready checks.
    initial begin
        bit           stallPrev;
        logic [W-1:0] heldValue;
        logic [3:0]   heldFlags;
        exp_t         e;
        stallPrev = 1'b0;
        heldValue = '0;
        heldFlags = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stallPrev = 1'b0;
                continue;
            end
            if (stallPrev) begin
                check("hold value", bus.out_value, heldValue);
                check("hold flags", W'({bus.out_flag, bus.out_gt, bus.out_eq, bus.out_lt}), W'(heldFlags));
            end
            if (bus.out_valid && !bus.out_ready)
                check("in_ready during stall", W'(bus.in_ready), W'(0));
            if (bus.out_valid && bus.out_ready) begin
                check("onehot", W'($countones({bus.out_gt, bus.out_eq, bus.out_lt})), W'(1));
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected output: value 0x%0h, none pending", bus.out_value);
                end else begin
                    e = sb.pop_front();
                    if (e.checkVal) check($sformatf("value tag %0d", e.tag), bus.out_value, e.value);
                    check($sformatf("flag/gt/eq/lt tag %0d", e.tag),
                          W'({bus.out_flag, bus.out_gt, bus.out_eq, bus.out_lt}),
                          W'({e.flag, e.gt, e.eq, e.lt}));
                end
            end
            stallPrev = bus.out_valid && !bus.out_ready;
            heldValue = bus.out_value;
            heldFlags = {bus.out_flag, bus.out_gt, bus.out_eq, bus.out_lt};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t dummy;
        logic [2:0] op;
        tbl[0]  = mkv(3'd0, 18'h10000, 18'h0F800, 0, 1, 0, 18'h0,     1, 1, 0, 0);
        tbl[1]  = mkv(3'd2, 18'h00000, 18'h20000, 0, 1, 0, 18'h0,     1, 0, 1, 0);
        tbl[2]  = mkv(3'd4, 18'h00000, 18'h20000, 0, 1, 1, 18'h00000, 0, 0, 1, 0);
        tbl[3]  = mkv(3'd3, 18'h30000, 18'h2F800, 0, 1, 0, 18'h0,     1, 0, 0, 1);
        tbl[4]  = mkv(3'd5, 18'h30000, 18'h2F800, 0, 1, 1, 18'h2F800, 0, 0, 0, 1);
        tbl[5]  = mkv(3'd3, 18'h2F800, 18'h30000, 0, 1, 0, 18'h0,     0, 1, 0, 0);
        tbl[6]  = mkv(3'd5, 18'h2F800, 18'h30000, 0, 1, 1, 18'h2F800, 0, 1, 0, 0);
        tbl[7]  = mkv(3'd0, 18'h2F800, 18'h30000, 0, 1, 0, 18'h0,     1, 1, 0, 0);
        tbl[8]  = mkv(3'd4, 18'h20000, 18'h00000, 0, 1, 1, 18'h20000, 0, 0, 1, 0);
        tbl[9]  = mkv(3'd1, 18'h0F800, 18'h0F800, 0, 1, 0, 18'h0,     1, 0, 1, 0);
        tbl[10] = mkv(3'd3, 18'h10000, 18'h20000, 0, 1, 0, 18'h0,     0, 1, 0, 0);
        tbl[11] = mkv(3'd0, 18'h3FFFF, 18'h1FFFF, 0, 1, 0, 18'h0,     0, 0, 0, 1);
        tbl[12] = mkv(3'd5, 18'h1F800, 18'h1F000, 0, 1, 1, 18'h1F800, 0, 1, 0, 0);
        tbl[13] = mkv(3'd7, 18'h0F800, 18'h0,     0, 0, 0, 18'h0,     0, 0, 0, 0);
        tbl[14] = mkv(3'd7, 18'h30000, 18'h0,     0, 0, 0, 18'h0,     0, 0, 0, 0);
        tbl[15] = mkv(3'd7, 18'h10000, 18'h0,     0, 0, 0, 18'h0,     0, 0, 0, 0);
        tbl[16] = mkv(3'd7, 18'h10000, 18'h0,     1, 1, 1, 18'h10000, 0, 0, 1, 0);
        tbl[17] = mkv(3'd6, 18'h2F800, 18'h0,     1, 1, 1, 18'h2F800, 0, 0, 1, 0);
        tbl[18] = mkv(3'd6, 18'h10000, 18'h0,     0, 0, 0, 18'h0,     0, 0, 0, 0);
        tbl[19] = mkv(3'd0, 18'h0F800, 18'h00000, 0, 1, 0, 18'h0,     1, 1, 0, 0);
        tbl[20] = mkv(3'd6, 18'h0F800, 18'h0,     1, 1, 1, 18'h0F800, 0, 0, 0, 1);
        dummy = tbl[0];

        bus.in_valid = 1'b0;
        bus.in_x = '0;
        bus.in_y = '0;
        bus.in_op = '0;
        bus.in_last = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", W'(bus.out_valid), W'(0));
        check("reset out_value", bus.out_value, W'(0));
        check("reset flags", W'({bus.out_flag, bus.out_gt, bus.out_eq, bus.out_lt}), W'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready after reset", W'(bus.in_ready), W'(1));

        // Latency: accepted at edge k, out_valid visible after edge k+1
        send(18'h10000, 18'h0F800, 3'd0, 1'b0, 1'b0, dummy, 100);
        @(negedge clk);
        check("latency cycle1 out_valid", W'(bus.out_valid), W'(0));
        @(negedge clk);
        check("latency cycle2 out_valid", W'(bus.out_valid), W'(1));
        @(posedge clk);
        #1;

        // Directed table, back to back
        for (int i = 0; i < NVEC; i++)
            send(tbl[i].x, tbl[i].y, tbl[i].op, tbl[i].last, 1'b1, tbl[i], i);
        drain("drain table");

        // Reset mid-stream: partial reduction, two compares in the pipe, one beat waiting
        readyMode = 3;
        @(posedge clk);
        #1;
        send(18'h10000, 18'h0, 3'd7, 1'b0, 1'b0, dummy, 200);
        send(18'h10000, 18'h0F800, 3'd0, 1'b0, 1'b0, dummy, 201);
        send(18'h0F800, 18'h10000, 3'd3, 1'b0, 1'b0, dummy, 202);
        bus.in_valid = 1'b1;
        bus.in_x = 18'h30000;
        bus.in_op = 3'd1;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        mAccFull = 1'b0;
        @(negedge clk);
        check("mid reset out_valid", W'(bus.out_valid), W'(0));
        check("mid reset out_value", bus.out_value, W'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        readyMode = 0;
        send(18'h0F800, 18'h0, 3'd7, 1'b1, 1'b0, dummy, 203);
        send(18'h2F800, 18'h10000, 3'd0, 1'b0, 1'b0, dummy, 204);
        drain("drain after reset");

        // Backpressure: six GE beats against a 1,0,0 out_ready pattern
        readyMode = 1;
        for (int i = 0; i < 6; i++)
            send(W'(18'h0F800 + i * 18'h400), W'(18'h10000 - i * 18'h200), 3'd1, 1'b0, 1'b0, dummy, 300 + i);
        drain("drain backpressure");

        // Random stream with random backpressure
        readyMode = 2;
        for (int i = 0; i < 200; i++) begin
            op = 3'($urandom_range(0, 7));
            send(pickVal(), pickVal(), op, 1'($urandom_range(0, 3) == 0), 1'b0, dummy, 1000 + i);
        end
        send(pickVal(), 18'h0, 3'd6, 1'b1, 1'b0, dummy, 2000);
        readyMode = 0;
        drain("drain random");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
